// File: rtl/board_tx.sv
`default_nettype none
// ============================================================================
// Module      : board_tx
// Description : Serial transmitter for a 9-cell board word. Frame is one
//               start bit (0), WIDTH data bits LSB first, one even-parity bit,
//               and one stop bit (1), each held for DIV cycles. All state is
//               built from ph2 master / ph1 slave latch pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module board_tx #(
  parameter int WIDTH = 18,
  parameter int DIV   = 4
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] board,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam int SW = 3 + DW + BW + WIDTH + 4;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    div_q,   div_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic             par_q,   par_d;
  logic             sout_q,  sout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Whole state travels as one vector through a single master/slave pair.
  logic [SW-1:0]    lat_d;
  logic [SW-1:0]    lat_m_q;
  logic [SW-1:0]    lat_s_q;

  logic             div_end;

  assign div_end = (div_q == DIV_LAST);

  assign lat_d = {state_d, div_d, bit_d, sh_d, par_d, sout_d, busy_d, done_d};
  assign {state_q, div_q, bit_q, sh_q, par_q, sout_q, busy_q, done_q} = lat_s_q;

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

  // Next-state logic: sout_d is the line value for the state being entered,
  // so the line is registered and never sees start/board combinationally.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sout_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_START;
          sh_d    = board;
          par_d   = ^board;
          div_d   = '0;
          bit_d   = '0;
          sout_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          sout_d  = sh_q[0];
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_PARITY;
            sout_d  = par_q;
          end else begin
            bit_d  = bit_q + 1'b1;
            sh_d   = {1'b0, sh_q[WIDTH-1:1]};
            sout_d = sh_q[1];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_STOP;
          sout_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_STOP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_IDLE;
          sout_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        sout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Synchronous reset wins over everything, including a same-cycle start.
    if (reset) begin
      state_d = S_IDLE;
      div_d   = '0;
      bit_d   = '0;
      sh_d    = '0;
      par_d   = 1'b0;
      sout_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Master latch: samples next state while ph2 is high.
  always_latch begin
    if (ph2) lat_m_q <= lat_d;
  end

  // Slave latch: presents the new state while ph1 is high.
  always_latch begin
    if (ph1) lat_s_q <= lat_m_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_board_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_tx
// Description : Directed checks of board_tx at DIV=4 and DIV=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_tx;

  logic        ph1 = 1'b0;
  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] board = '0;
  logic        sout_a, busy_a, done_a;
  logic        sout_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [17:0] brd;
    logic        par;
  } vec_t;

  vec_t vecs [8];

  board_tx #(.WIDTH(18), .DIV(4)) u_dut4 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .start(start), .board(board),
    .sout(sout_a), .busy(busy_a), .done(done_a)
  );

  board_tx #(.WIDTH(18), .DIV(1)) u_dut1 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .start(start), .board(board),
    .sout(sout_b), .busy(busy_b), .done(done_b)
  );

  // Non-overlapping two-phase clock, period 10.
  initial begin
    forever begin
      #2 ph2 = 1'b1;
      #3 ph2 = 1'b0;
      #2 ph1 = 1'b1;
      #3 ph1 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Sample point: just after ph1 falls, before the next ph2.
  task automatic step();
    @(negedge ph1);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic so_of(input int dv);
    return (dv == 1) ? sout_b : sout_a;
  endfunction

  function automatic logic by_of(input int dv);
    return (dv == 1) ? busy_b : busy_a;
  endfunction

  function automatic logic dn_of(input int dv);
    return (dv == 1) ? done_b : done_a;
  endfunction

  // Called at the sample point of the start cycle; returns at the done cycle.
  task automatic run_frame(input int dv, input logic [17:0] brd, input logic par,
                           input bit hold, input int glitch, input string tag);
    int len;
    len = 21 * dv;
    chk({tag, " idle busy"}, by_of(dv), 0);
    start = 1'b1;
    board = brd;
    step();
    if (!hold) begin
      start = 1'b0;
      board = ~brd;
    end
    for (int c = 1; c <= len; c++) begin
      int   b;
      logic e;
      b = (c - 1) / dv;
      if (b == 0)       e = 1'b0;
      else if (b <= 18) e = brd[b-1];
      else if (b == 19) e = par;
      else              e = 1'b1;
      chk($sformatf("%s sout c%0d", tag, c), so_of(dv), e);
      chk($sformatf("%s busy c%0d", tag, c), by_of(dv), 1);
      chk($sformatf("%s done c%0d", tag, c), dn_of(dv), 0);
      if (c == glitch) begin
        start = 1'b1;
        board = '0;
      end else if (c == glitch + 1) begin
        start = 1'b0;
      end
      step();
    end
    chk({tag, " done pulse"}, dn_of(dv), 1);
    chk({tag, " busy end"}, by_of(dv), 0);
    chk({tag, " sout end"}, so_of(dv), 1);
  endtask

  initial begin
    int npulse;
    vecs[0] = '{18'h00001, 1'b1};
    vecs[1] = '{18'h3FFFF, 1'b0};
    vecs[2] = '{18'h2AAAA, 1'b1};
    vecs[3] = '{18'h12345, 1'b1};
    vecs[4] = '{18'h00000, 1'b0};
    vecs[5] = '{18'h20000, 1'b1};
    vecs[6] = '{18'h0F0F0, 1'b0};
    vecs[7] = '{18'h3C00F, 1'b0};

    // Reset state
    repeat (3) step();
    chk("rst sout4", sout_a, 1);
    chk("rst busy4", busy_a, 0);
    chk("rst done4", done_a, 0);
    chk("rst sout1", sout_b, 1);
    chk("rst busy1", busy_b, 0);
    chk("rst done1", done_b, 0);

    // Reset overrides a same-cycle start
    start = 1'b1;
    board = 18'h3FFFF;
    step();
    chk("rst vs start busy", busy_a, 0);
    chk("rst vs start sout", sout_a, 1);
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("post rst busy", busy_a, 0);

    // Table-driven frames at DIV=4
    for (int i = 0; i < 8; i++) begin
      run_frame(4, vecs[i].brd, vecs[i].par, 1'b0, -1, $sformatf("vec%0d", i));
      step();
      chk($sformatf("vec%0d done one-shot", i), done_a, 0);
      chk($sformatf("vec%0d idle busy", i), busy_a, 0);
    end

    // start held high: back-to-back frames with one idle cycle between
    run_frame(4, 18'h2AAAA, 1'b1, 1'b1, -1, "b2b1");
    run_frame(4, 18'h2AAAA, 1'b1, 1'b1, -1, "b2b2");
    start = 1'b0;
    step();
    chk("b2b stop busy", busy_a, 0);
    chk("b2b stop done", done_a, 0);

    // start re-pulsed and board zeroed mid-frame: ignored, no queued frame
    run_frame(4, 18'h12345, 1'b1, 1'b0, 30, "glitch");
    step();
    chk("glitch no requeue busy", busy_a, 0);
    step();
    chk("glitch no requeue busy2", busy_a, 0);

    // Reset at cycle 40 of a frame aborts it
    start = 1'b1;
    board = 18'h3FFFF;
    step();
    start = 1'b0;
    repeat (39) step();
    chk("abort pre busy", busy_a, 1);
    reset = 1'b1;
    step();
    chk("abort sout", sout_a, 1);
    chk("abort busy", busy_a, 0);
    chk("abort done", done_a, 0);
    reset = 1'b0;
    npulse = 0;
    for (int k = 0; k < 90; k++) begin
      step();
      if (done_a === 1'b1 || busy_a === 1'b1) npulse++;
    end
    chk("abort no done/busy", npulse, 0);
    run_frame(4, 18'h00001, 1'b1, 1'b0, -1, "post-abort");
    step();

    // DIV=1 instance: one cycle per bit
    run_frame(1, 18'h00003, 1'b0, 1'b0, -1, "div1");
    step();
    chk("div1 done one-shot", done_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_tx.md
BOARD_TX -- requirements
Module: board_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 18, meaning the board word width (9 cells x 2 bits).
REQ-002 SHALL provide parameter DIV, default 4, meaning cycles per serial bit (legal range 1..255).
REQ-003 SHALL provide port ph1  input  1  phase-1 clock; all state updates at the end of ph1.
REQ-004 SHALL provide port ph2  input  1  phase-2 clock, non-overlapping with ph1.
REQ-005 SHALL provide port reset  input  1  synchronous active-high reset, sampled with the state update.
REQ-006 SHALL provide port start  input  1  request to transmit the current board word.
REQ-007 SHALL provide port board  input  WIDTH  board word to transmit; cell k occupies bits [2k+1:2k].
REQ-008 SHALL provide port sout  output  1  serial line, idle high.
REQ-009 SHALL provide port busy  output  1  frame in progress; start is ignored while high.
REQ-010 SHALL provide port done  output  1  one-cycle pulse at frame completion.
REQ-011 SHALL run in one clock domain: one clock, carried on the non-overlapping ph1/ph2 pair; reset is synchronous and active-high; one cycle equals one ph1/ph2 period.
REQ-012 SHALL build every state element from master (ph2) / slave (ph1) latch pairs; there SHALL be no other storage.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE, start=1 SHALL capture board into a shift register and enter START on the next cycle.
REQ-015 START SHALL drive sout=0 for DIV cycles, then enter DATA.
REQ-016 DATA SHALL drive the shift register LSB first, bit 0 through bit WIDTH-1, each bit for DIV cycles.
REQ-017 After bit WIDTH-1, DATA SHALL enter PARITY.
REQ-018 PARITY SHALL drive the even-parity bit, the XOR of all WIDTH captured bits, for DIV cycles.
REQ-019 STOP SHALL drive sout=1 for DIV cycles, then return to IDLE.
REQ-020 Frame length SHALL be exactly (WIDTH+3)*DIV cycles, from the first START cycle through the last STOP cycle.
REQ-021 busy SHALL be 1 in every START, DATA, PARITY and STOP cycle, and 0 in IDLE.
REQ-022 done SHALL be 1 only in the first IDLE cycle after STOP.
REQ-023 The divider counter SHALL count 0..DIV-1 and wrap to 0 at each bit boundary.
REQ-024 The bit counter SHALL count 0..WIDTH-1; its width SHALL be $clog2(WIDTH).
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 Changes on board after capture SHALL NOT affect the frame.
REQ-027 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back frames separated by exactly one idle-high cycle.
REQ-028 sout SHALL be a registered output, with no combinational path from start or board to sout.
REQ-029 With DIV=1, each frame bit SHALL last exactly one cycle.

Reset
REQ-030 Reset SHALL force IDLE, sout=1, busy=0, done=0, and zero in both counters and the shift register, on the next state update.
REQ-031 Reset SHALL override start in the same cycle.
REQ-032 Reset mid-frame SHALL abort the frame immediately, with no done pulse and sout=1 from the next cycle.
REQ-033 After reset deasserts, the first start SHALL produce a complete, correct frame.

Verification
REQ-034 Scenario: DIV=4, board=18'h00001, start pulse -> sout 0 for 4 cycles, 1 for 4, 0 for 68, parity 1 for 4, stop 1 for 4; done 85 cycles after start.
REQ-035 Scenario: board=18'h3FFFF -> 18 data bits all 1, parity 0; busy high for exactly 84 cycles.
REQ-036 Scenario: start held high continuously, board=18'h2AAAA -> repeated identical frames, each separated by one idle cycle; done pulses every 85 cycles.
REQ-037 Scenario: start re-pulsed and board changed to 18'h00000 at cycle 30 of a frame -> the original frame completes unchanged, and no second frame follows.
REQ-038 Scenario: reset asserted at cycle 40 of a frame -> sout=1, busy=0 the next cycle, no done pulse; a new start then yields a correct full frame.
REQ-039 Scenario: DIV=1, board=18'h00003 -> 21-cycle frame 0,1,1,0x16,0,1; done on cycle 22.
